dot_prod_peak: RTL and testbench

//  Sink for the dot-product result stream in the CAF datapath. Accepts one complex

---
 rtl/dot_prod_peak_pkg.sv | 25 ++
 rtl/cpx_mag_sq.sv | 69 ++++++
 rtl/dot_prod_peak.sv | 157 +++++++++++++++
 tb/tb_dot_prod_peak.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_peak_pkg.sv
// dot_prod_peak_pkg
//   Shared definitions for the dot-product peak detector:
//   - state_e      : frame sequencing states (SCAN, DRAIN, OUT)
//   - PIPE_DEPTH   : clocks from accepting a result to the peak register update
//                    plus the output load (2 magnitude stages + 1 compare stage)
//   - min_mag_bits : smallest magnitude width that holds |i|^2+|q|^2 without wrap
package dot_prod_peak_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int PIPE_DEPTH = 3;

  // Most-negative input on both rails gives 2*2^(2*bits-2) = 2^(2*bits-1),
  // which needs 2*bits bits unsigned; one extra bit keeps headroom.
  function automatic int min_mag_bits(input int i_bits, input int q_bits);
    int widest;
    widest = (i_bits > q_bits) ? i_bits : q_bits;
    return 2 * widest + 1;
  endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// cpx_mag_sq
//   Two-stage registered squared magnitude |i|^2+|q|^2 with valid and tag
//   carried alongside the data.
//   Ports:
//     clk, n_reset       clock, asynchronous active-low reset
//     in_valid/in_i/in_q/in_tag   sample entering stage 1
//     out_valid/out_mag/out_tag   result leaving stage 2
//     busy               high while any stage holds a valid sample
module cpx_mag_sq #(
  parameter int i_bits   = 24,
  parameter int q_bits   = 24,
  parameter int mag_bits = 49,
  parameter int tag_bits = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       in_valid,
  input  logic signed [i_bits-1:0]   in_i,
  input  logic signed [q_bits-1:0]   in_q,
  input  logic        [tag_bits-1:0] in_tag,
  output logic                       out_valid,
  output logic        [mag_bits-1:0] out_mag,
  output logic        [tag_bits-1:0] out_tag,
  output logic                       busy
);

  logic signed [2*i_bits-1:0] i_ext, ii_d, ii_q;
  logic signed [2*q_bits-1:0] q_ext, qq_d, qq_q;
  logic                       s1_valid_q, s2_valid_q;
  logic        [tag_bits-1:0] s1_tag_q, s2_tag_q;
  logic        [mag_bits-1:0] mag_d, mag_q;

  // Operands are sign-extended to the product width first so the truncated
  // product is the exact signed square.
  always_comb begin
    i_ext = {{i_bits{in_i[i_bits-1]}}, in_i};
    q_ext = {{q_bits{in_q[q_bits-1]}}, in_q};
    ii_d  = i_ext * i_ext;
    qq_d  = q_ext * q_ext;
    // Squares are non-negative, so zero extension is exact.
    mag_d = {{(mag_bits-2*i_bits){1'b0}}, ii_q} + {{(mag_bits-2*q_bits){1'b0}}, qq_q};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      ii_q       <= '0;
      qq_q       <= '0;
      mag_q      <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_tag_q   <= in_tag;
      ii_q       <= ii_d;
      qq_q       <= qq_d;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      mag_q      <= mag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mag   = mag_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/dot_prod_peak.sv
// dot_prod_peak
//   Collects num_lags complex correlation results per frame, finds the largest
//   |i|^2+|q|^2 (earliest lag wins ties) and offers it on a valid/ready output.
//   Ports:
//     clk, n_reset             clock, asynchronous active-low reset
//     s_axis_product_tvalid, i, q, m_axis_product_tready   result input stream
//     s_axis_peak_tvalid, peak_index, peak_mag, m_axis_peak_tready   peak output
//     threshold                only with PEAK_THRESHOLD_EN: frames whose peak is
//                              <= threshold are dropped silently
//   Build option: define PEAK_THRESHOLD_EN to add the threshold input.
module dot_prod_peak
  import dot_prod_peak_pkg::*;
#(
  parameter int i_bits           = 24,
  parameter int q_bits           = 24,
  parameter int num_lags         = 16,
  parameter int lag_counter_bits = 4,
  parameter int mag_bits         = 49
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        s_axis_product_tvalid,
  input  logic signed [i_bits-1:0]    i,
  input  logic signed [q_bits-1:0]    q,
  output logic                        m_axis_product_tready,
`ifdef PEAK_THRESHOLD_EN
  input  logic [mag_bits-1:0]         threshold,
`endif
  input  logic                        m_axis_peak_tready,
  output logic                        s_axis_peak_tvalid,
  output logic [lag_counter_bits-1:0] peak_index,
  output logic [mag_bits-1:0]         peak_mag
);

  localparam int LB = lag_counter_bits;

  state_e              state_q, state_d;
  logic [LB-1:0]       count_q, count_d;
  logic [mag_bits-1:0] best_mag_q, best_mag_d;
  logic [LB-1:0]       best_index_q, best_index_d;
  logic                peak_valid_q, peak_valid_d;
  logic [LB-1:0]       peak_index_q, peak_index_d;
  logic [mag_bits-1:0] peak_mag_q, peak_mag_d;
  logic                tready_q, tready_d;

  logic                transfer;
  logic                mag_valid;
  logic [mag_bits-1:0] mag_value;
  logic [LB-1:0]       mag_tag;
  logic                pipe_busy;

  assign transfer = s_axis_product_tvalid && tready_q;

  cpx_mag_sq #(
    .i_bits   (i_bits),
    .q_bits   (q_bits),
    .mag_bits (mag_bits),
    .tag_bits (LB)
  ) u_mag (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (transfer),
    .in_i      (i),
    .in_q      (q),
    .in_tag    (count_q),
    .out_valid (mag_valid),
    .out_mag   (mag_value),
    .out_tag   (mag_tag),
    .busy      (pipe_busy)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    best_mag_d   = best_mag_q;
    best_index_d = best_index_q;
    peak_valid_d = peak_valid_q;
    peak_index_d = peak_index_q;
    peak_mag_d   = peak_mag_q;

    // Lag 0 always seeds the running best, so a stale best never leaks
    // into a new frame; strict compare keeps the earliest lag on ties.
    if (mag_valid && ((mag_tag == '0) || (mag_value > best_mag_q))) begin
      best_mag_d   = mag_value;
      best_index_d = mag_tag;
    end

    case (state_q)
      SCAN: begin
        if (transfer) begin
          if (count_q == LB'(num_lags - 1)) state_d = DRAIN;
          else                              count_d = count_q + 1'b1;
        end
      end
      DRAIN: begin
        // Both magnitude stages empty means the last lag has been compared.
        if (!pipe_busy) begin
`ifdef PEAK_THRESHOLD_EN
          if (best_mag_q <= threshold) begin
            state_d      = SCAN;
            count_d      = '0;
            best_mag_d   = '0;
            best_index_d = '0;
          end else begin
`else
          begin
`endif
            state_d      = OUT;
            peak_valid_d = 1'b1;
            peak_index_d = best_index_q;
            peak_mag_d   = best_mag_q;
          end
        end
      end
      OUT: begin
        if (m_axis_peak_tready) begin
          peak_valid_d = 1'b0;
          state_d      = SCAN;
          count_d      = '0;
          best_mag_d   = '0;
          best_index_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase

    tready_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= SCAN;
      count_q      <= '0;
      best_mag_q   <= '0;
      best_index_q <= '0;
      peak_valid_q <= 1'b0;
      peak_index_q <= '0;
      peak_mag_q   <= '0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      best_mag_q   <= best_mag_d;
      best_index_q <= best_index_d;
      peak_valid_q <= peak_valid_d;
      peak_index_q <= peak_index_d;
      peak_mag_q   <= peak_mag_d;
      tready_q     <= tready_d;
    end
  end

  assign m_axis_product_tready = tready_q;
  assign s_axis_peak_tvalid    = peak_valid_q;
  assign peak_index            = peak_index_q;
  assign peak_mag              = peak_mag_q;

endmodule

// File: tb/tb_dot_prod_peak.sv
// tb_dot_prod_peak
//   Directed frames from a vector table, a hold/backpressure sequence, random
//   valid gaps against a small reference model, mid-frame reset and (when
//   PEAK_THRESHOLD_EN is defined) threshold discard.
module tb_dot_prod_peak;
  import dot_prod_peak_pkg::*;

  localparam int IB = 8;
  localparam int QB = 8;
  localparam int NL = 4;
  localparam int LB = 2;
  localparam int MB = min_mag_bits(IB, QB);

  logic                 clk = 1'b0;
  logic                 n_reset = 1'b1;
  logic                 s_valid;
  logic signed [IB-1:0] i_in;
  logic signed [QB-1:0] q_in;
  logic                 tready;
  logic                 peak_ready;
  logic                 peak_valid;
  logic [LB-1:0]        peak_index;
  logic [MB-1:0]        peak_mag;
`ifdef PEAK_THRESHOLD_EN
  logic [MB-1:0]        threshold;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dot_prod_peak #(
    .i_bits           (IB),
    .q_bits           (QB),
    .num_lags         (NL),
    .lag_counter_bits (LB),
    .mag_bits         (MB)
  ) dut (
    .clk                   (clk),
    .n_reset               (n_reset),
    .s_axis_product_tvalid (s_valid),
    .i                     (i_in),
    .q                     (q_in),
    .m_axis_product_tready (tready),
`ifdef PEAK_THRESHOLD_EN
    .threshold             (threshold),
`endif
    .m_axis_peak_tready    (peak_ready),
    .s_axis_peak_tvalid    (peak_valid),
    .peak_index            (peak_index),
    .peak_mag              (peak_mag)
  );

  typedef struct {
    int iv [NL];
    int qv [NL];
    int exp_idx;
    int exp_mag;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Offers one result, optionally preceded by random idle cycles, and waits
  // (bounded) until it is accepted.
  task automatic applyStimulus(input int iv, input int qv, input int gap_pct);
    logic ok;
    int   w;
    for (int g = 0; g < 8; g++) begin
      if ($urandom_range(99, 0) >= gap_pct) break;
      tick();
    end
    s_valid = 1'b1;
    i_in    = IB'(iv);
    q_in    = QB'(qv);
    w       = 0;
    do begin
      ok = tready;
      tick();
      w++;
    end while (!ok && w < 50);
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    i_in    = '0;
    q_in    = '0;
  endtask

  task automatic sendFrame(input vec_t v, input int gap_pct);
    for (int k = 0; k < NL; k++) applyStimulus(v.iv[k], v.qv[k], gap_pct);
  endtask

  // Returns the number of clocks after the last accepted lag until valid
  // rises, or 0 if it never does within the window.
  task automatic waitPeak(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (peak_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic takePeak(input int exp_idx, input int exp_mag);
    checkOutput("peak_index", 32'(peak_index), 32'(exp_idx));
    checkOutput("peak_mag", 32'(peak_mag), 32'(exp_mag));
    checkOutput("tready_in_out", 32'(tready), 32'd0);
    peak_ready = 1'b1;
    tick();
    peak_ready = 1'b0;
    checkOutput("valid_after_take", 32'(peak_valid), 32'd0);
    checkOutput("tready_after_take", 32'(tready), 32'd1);
  endtask

  initial begin
    int   cyc;
    logic hold_ok;
    vec_t rv;

    vecs[0] = '{iv: '{3, 0, -6, 1},       qv: '{4, 0, 8, 1},        exp_idx: 2, exp_mag: 100};
    vecs[1] = '{iv: '{5, 0, 3, 1},        qv: '{0, -5, 4, 0},       exp_idx: 0, exp_mag: 25};
    vecs[2] = '{iv: '{-128, -128, -128, -128}, qv: '{-128, -128, -128, -128}, exp_idx: 0, exp_mag: 32768};
    vecs[3] = '{iv: '{0, 0, 0, 0},        qv: '{1, 2, 3, 0},        exp_idx: 2, exp_mag: 9};
    vecs[4] = '{iv: '{1, 2, -7, 7},       qv: '{0, 0, 0, 0},        exp_idx: 2, exp_mag: 49};
    vecs[5] = '{iv: '{0, 0, 0, 0},        qv: '{0, 0, 0, -1},       exp_idx: 3, exp_mag: 1};

    s_valid    = 1'b0;
    i_in       = '0;
    q_in       = '0;
    peak_ready = 1'b0;
`ifdef PEAK_THRESHOLD_EN
    threshold  = '0;
`endif

    #2 n_reset = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", 32'(peak_valid), 32'd0);
    checkOutput("reset_index", 32'(peak_index), 32'd0);
    checkOutput("reset_mag", 32'(peak_mag), 32'd0);
    checkOutput("reset_tready", 32'(tready), 32'd0);
    n_reset = 1'b1;
    tick();
    checkOutput("tready_after_reset", 32'(tready), 32'd1);

    $display("[TB] directed vector table");
    for (int v = 0; v < 6; v++) begin
      sendFrame(vecs[v], 0);
      waitPeak(cyc);
      checkOutput("latency", 32'(cyc), 32'(PIPE_DEPTH));
      if (cyc != 0) takePeak(vecs[v].exp_idx, vecs[v].exp_mag);
    end

    $display("[TB] backpressure hold");
    sendFrame(vecs[2], 0);
    waitPeak(cyc);
    checkOutput("hold_latency", 32'(cyc), 32'(PIPE_DEPTH));
    for (int h = 0; h < 10; h++) begin
      tick();
      hold_ok = peak_valid && (peak_index == 2'd0) && (peak_mag == 17'd32768) && !tready;
      checkOutput("hold_stable", 32'(hold_ok), 32'd1);
    end
    takePeak(0, 32768);

    $display("[TB] random gaps vs model");
    for (int f = 0; f < 3; f++) begin
      rv.exp_idx = 0;
      rv.exp_mag = 0;
      for (int k = 0; k < NL; k++) begin
        rv.iv[k] = (k == 0) ? int'($urandom_range(127, 1)) : int'($urandom_range(255, 0)) - 128;
        rv.qv[k] = int'($urandom_range(255, 0)) - 128;
      end
      for (int k = 0; k < NL; k++) begin
        int m;
        m = rv.iv[k] * rv.iv[k] + rv.qv[k] * rv.qv[k];
        if (k == 0 || m > rv.exp_mag) begin
          rv.exp_mag = m;
          rv.exp_idx = k;
        end
      end
      sendFrame(rv, 50);
      waitPeak(cyc);
      checkOutput("rand_latency", 32'(cyc), 32'(PIPE_DEPTH));
      repeat ($urandom_range(3, 0)) tick();
      if (cyc != 0) takePeak(rv.exp_idx, rv.exp_mag);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(9, 9, 0);
    applyStimulus(10, 10, 0);
    n_reset = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(peak_valid), 32'd0);
    checkOutput("midreset_index", 32'(peak_index), 32'd0);
    checkOutput("midreset_mag", 32'(peak_mag), 32'd0);
    checkOutput("midreset_tready", 32'(tready), 32'd0);
    tick();
    n_reset = 1'b1;
    sendFrame(vecs[3], 0);
    waitPeak(cyc);
    checkOutput("post_reset_latency", 32'(cyc), 32'(PIPE_DEPTH));
    if (cyc != 0) takePeak(2, 9);

`ifdef PEAK_THRESHOLD_EN
    $display("[TB] threshold discard");
    threshold = 17'd50;
    sendFrame(vecs[1], 0);
    waitPeak(cyc);
    checkOutput("thr_discard", 32'(cyc), 32'd0);
    checkOutput("thr_tready", 32'(tready), 32'd1);
    sendFrame(vecs[0], 0);
    waitPeak(cyc);
    checkOutput("thr_pass_latency", 32'(cyc), 32'(PIPE_DEPTH));
    if (cyc != 0) takePeak(2, 100);
    threshold = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
